traffic_lamp_monitor: RTL

- Receive-side observer for the two-approach traffic signal: reads the decoded one-hot R/Y/G lamp lines of approach A and approach B.
- Re-encodes each approach's lamps to the 2-bit phase code the controller counters produce.
- Checks lamp validity, A/B conflict, bounce-sequence legality (R→Y→G→Y→R) and minimum dwell; latches the first fault.
- Sits beside the controller/decoder pair as a self-checking safety monitor, usable in the bench and in silicon.

---
 rtl/traffic_lamp_monitor_if.sv | 32 +++
 rtl/traffic_lamp_monitor.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/traffic_lamp_monitor_if.sv
// rtl/traffic_lamp_monitor_if.sv - lamp inputs and monitor status bundle for traffic_lamp_monitor
//
// Purpose: groups the observed lamp lines and the monitor's status outputs.
//   master : the side that drives the lamps (controller/decoder or bench) and reads status
//   slave  : the monitor; reads the lamps and drives status
// Signals:
//   a_r/a_y/a_g, b_r/b_y/b_g : one-hot lamp lines for approaches A and B
//   a_code/b_code            : encoded phase (00 RED, 01 YEL, 10 GRN, 11 INVALID)
//   a_dwell/b_dwell          : cycles the current code has been held (saturating)
//   fault/fault_code         : sticky fault flag and first fault cause
//   cycle_count              : completed A cycles, wraps at 8 bits
interface traffic_lamp_monitor_if #(
  parameter int CNT_W = 8
);
  logic             a_r, a_y, a_g;
  logic             b_r, b_y, b_g;
  logic [1:0]       a_code, b_code;
  logic [CNT_W-1:0] a_dwell, b_dwell;
  logic             fault;
  logic [2:0]       fault_code;
  logic [7:0]       cycle_count;

  modport master (
    output a_r, a_y, a_g, b_r, b_y, b_g,
    input  a_code, b_code, a_dwell, b_dwell, fault, fault_code, cycle_count
  );

  modport slave (
    input  a_r, a_y, a_g, b_r, b_y, b_g,
    output a_code, b_code, a_dwell, b_dwell, fault, fault_code, cycle_count
  );
endinterface

// File: rtl/traffic_lamp_monitor.sv
// rtl/traffic_lamp_monitor.sv - safety monitor for a two-approach traffic signal
//
// Purpose: re-encodes approach A/B lamps to phase codes, checks lamp validity,
//   A/B green conflict, R->Y->G->Y->R sequence legality and minimum dwell, and
//   latches the first fault. All outputs lag the sampled lamps by one cycle.
// Ports:
//   i_clk    : system clock, rising edge
//   i_reset  : synchronous active-high reset
//   io_mon   : traffic_lamp_monitor_if.slave (lamps in, status out)
module traffic_lamp_monitor #(
  parameter int MIN_DWELL = 2,
  parameter int CNT_W     = 8
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  traffic_lamp_monitor_if.slave  io_mon
);

  typedef enum logic [1:0] {S_RED, S_YEL_UP, S_GRN, S_YEL_DN} seq_state_e;

  localparam logic [1:0] C_RED = 2'b00;
  localparam logic [1:0] C_YEL = 2'b01;
  localparam logic [1:0] C_GRN = 2'b10;
  localparam logic [1:0] C_INV = 2'b11;

  localparam logic [CNT_W-1:0] L_MIN_DWELL = CNT_W'(MIN_DWELL);
  localparam logic [CNT_W-1:0] L_ONE       = CNT_W'(1);

  function automatic logic [1:0] encode(input logic r, input logic y, input logic g);
    case ({r, y, g})
      3'b100:  return C_RED;
      3'b010:  return C_YEL;
      3'b001:  return C_GRN;
      default: return C_INV;
    endcase
  endfunction

  // Yellow with no history is taken as the rising yellow.
  function automatic seq_state_e init_state(input logic [1:0] code);
    case (code)
      C_YEL:   return S_YEL_UP;
      C_GRN:   return S_GRN;
      default: return S_RED;
    endcase
  endfunction

  // The FSM state doubles as the previous-code register.
  function automatic logic [1:0] state_code(input seq_state_e s);
    case (s)
      S_YEL_UP, S_YEL_DN: return C_YEL;
      S_GRN:              return C_GRN;
      default:            return C_RED;
    endcase
  endfunction

  function automatic logic seq_illegal(input seq_state_e s, input logic [1:0] code);
    case (s)
      S_RED:    return code == C_GRN;
      S_YEL_UP: return code == C_RED;
      S_GRN:    return code == C_RED;
      S_YEL_DN: return code == C_GRN;
      default:  return 1'b0;
    endcase
  endfunction

  function automatic seq_state_e seq_legal_next(input seq_state_e s, input logic [1:0] code);
    case (s)
      S_RED:    return (code == C_YEL) ? S_YEL_UP : s;
      S_YEL_UP: return (code == C_GRN) ? S_GRN    : s;
      S_GRN:    return (code == C_YEL) ? S_YEL_DN : s;
      S_YEL_DN: return (code == C_RED) ? S_RED    : s;
      default:  return S_RED;
    endcase
  endfunction

  // Index 0 is approach A, index 1 is approach B.
  logic [1:0]       w_code      [2];
  logic [1:0]       w_valid;
  logic             w_arm_now;
  seq_state_e       r_state     [2];
  seq_state_e       w_state_nxt [2];
  logic [CNT_W-1:0] r_dwell     [2];
  logic [CNT_W-1:0] w_dwell_nxt [2];
  logic [1:0]       r_code      [2];
  logic [1:0]       w_illegal;
  logic [1:0]       w_short;
  logic             w_invalid;
  logic             w_conflict;
  logic [2:0]       w_fault_new;
  logic             w_cycle_done;
  logic             r_armed;
  logic             r_fault;
  logic [2:0]       r_fault_code;
  logic [7:0]       r_cycle_count;

  assign w_code[0] = encode(io_mon.a_r, io_mon.a_y, io_mon.a_g);
  assign w_code[1] = encode(io_mon.b_r, io_mon.b_y, io_mon.b_g);
  assign w_valid   = {w_code[1] != C_INV, w_code[0] != C_INV};
  assign w_arm_now = !r_armed && (&w_valid);

  // Next-state for both sequence FSMs and dwell counters. An invalid
  // approach keeps its state and dwell so checking resumes from there.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_state_nxt[i] = r_state[i];
      w_dwell_nxt[i] = r_dwell[i];
      w_illegal[i]   = 1'b0;
      w_short[i]     = 1'b0;
      if (w_arm_now) begin
        w_state_nxt[i] = init_state(w_code[i]);
        w_dwell_nxt[i] = L_ONE;
      end else if (r_armed && w_valid[i]) begin
        w_illegal[i]   = seq_illegal(r_state[i], w_code[i]);
        w_state_nxt[i] = w_illegal[i] ? init_state(w_code[i])
                                      : seq_legal_next(r_state[i], w_code[i]);
        if (w_code[i] != state_code(r_state[i])) begin
          w_dwell_nxt[i] = L_ONE;
          w_short[i]     = r_dwell[i] < L_MIN_DWELL;
        end else if (r_dwell[i] != '1) begin
          w_dwell_nxt[i] = r_dwell[i] + L_ONE;
        end
      end
    end
  end

  assign w_invalid    = r_armed && !(&w_valid);
  assign w_conflict   = (w_code[0] == C_GRN) && (w_code[1] == C_GRN);
  assign w_cycle_done = r_armed && w_valid[0] && (r_state[0] == S_YEL_DN) && (w_code[0] == C_RED);

  // Lowest fault code wins when several fire together.
  always_comb begin
    w_fault_new = 3'd0;
    if (w_invalid)       w_fault_new = 3'd1;
    else if (w_conflict) w_fault_new = 3'd2;
    else if (|w_illegal) w_fault_new = 3'd3;
    else if (|w_short)   w_fault_new = 3'd4;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < 2; i++) begin
        r_state[i] <= S_RED;
        r_dwell[i] <= '0;
        r_code[i]  <= C_RED;
      end
      r_armed       <= 1'b0;
      r_fault       <= 1'b0;
      r_fault_code  <= 3'd0;
      r_cycle_count <= 8'd0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_dwell[i] <= w_dwell_nxt[i];
        r_code[i]  <= w_code[i];
      end
      if (w_arm_now) r_armed <= 1'b1;
      if (!r_fault && (w_fault_new != 3'd0)) begin
        r_fault      <= 1'b1;
        r_fault_code <= w_fault_new;
      end
      if (w_cycle_done) r_cycle_count <= r_cycle_count + 8'd1;
    end
  end

  assign io_mon.a_code      = r_code[0];
  assign io_mon.b_code      = r_code[1];
  assign io_mon.a_dwell     = r_dwell[0];
  assign io_mon.b_dwell     = r_dwell[1];
  assign io_mon.fault       = r_fault;
  assign io_mon.fault_code  = r_fault_code;
  assign io_mon.cycle_count = r_cycle_count;

endmodule
